// File: rtl/vedic_mul_pipe.sv
// Three-stage RV32M multiplier (MUL/MULH/MULHSU/MULHU) built from half-width
// partial products. Optional statistics counters are enabled by VEDIC_MUL_STATS_EN.
module vedic_mul_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
`ifdef VEDIC_MUL_STATS_EN
  ,
  output logic [31:0]      stat_ops,
  output logic [31:0]      stat_stall
`endif
);

  localparam int H  = XLEN / 2;
  localparam int PW = 2 * XLEN;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  // Handshake: an op moves on a rising edge when valid && ready at that port.
  // The whole pipe freezes while a result waits on a non-ready consumer; flush
  // empties every stage and wins over the freeze and over a same-cycle input.
  logic stall;
  logic accept;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready & ~flush;

  // ---------------- S1: sign handling and partial products ----------------
  logic            a_signed;
  logic            b_signed;
  logic            sign_a;
  logic            sign_b;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            mag_zero;
  logic            neg_c;
  logic [XLEN-1:0] pp_ll;
  logic [XLEN-1:0] pp_lh;
  logic [XLEN-1:0] pp_hl;
  logic [XLEN-1:0] pp_hh;

  always_comb begin
    a_signed = (in_op == OP_MULH) || (in_op == OP_MULHSU);
    b_signed = (in_op == OP_MULH);
    sign_a   = a_signed & in_a[XLEN-1];
    sign_b   = b_signed & in_b[XLEN-1];
    // Two's-complement negate; the most negative value maps onto 2^(XLEN-1).
    mag_a    = sign_a ? (~in_a + XLEN'(1)) : in_a;
    mag_b    = sign_b ? (~in_b + XLEN'(1)) : in_b;
    mag_zero = (mag_a == '0) || (mag_b == '0);
    neg_c    = (sign_a ^ sign_b) & ~mag_zero;
    pp_ll    = XLEN'(mag_a[H-1:0])    * XLEN'(mag_b[H-1:0]);
    pp_lh    = XLEN'(mag_a[H-1:0])    * XLEN'(mag_b[XLEN-1:H]);
    pp_hl    = XLEN'(mag_a[XLEN-1:H]) * XLEN'(mag_b[H-1:0]);
    pp_hh    = XLEN'(mag_a[XLEN-1:H]) * XLEN'(mag_b[XLEN-1:H]);
  end

  logic             s1_valid;
  logic [XLEN-1:0]  s1_ll;
  logic [XLEN-1:0]  s1_lh;
  logic [XLEN-1:0]  s1_hl;
  logic [XLEN-1:0]  s1_hh;
  logic             s1_neg;
  logic [1:0]       s1_op;
  logic [TAG_W-1:0] s1_tag;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_ll  <= '0;
      s1_lh  <= '0;
      s1_hl  <= '0;
      s1_hh  <= '0;
      s1_neg <= 1'b0;
      s1_op  <= '0;
      s1_tag <= '0;
    end else if (accept) begin
      s1_ll  <= pp_ll;
      s1_lh  <= pp_lh;
      s1_hl  <= pp_hl;
      s1_hh  <= pp_hh;
      s1_neg <= neg_c;
      s1_op  <= in_op;
      s1_tag <= in_tag;
    end
  end

  // ---------------- S2: cross-term sum ----------------
  logic             s2_valid;
  logic [XLEN:0]    s2_cross;
  logic [H-1:0]     s2_ll_lo;
  logic [H-1:0]     s2_ll_hi;
  logic [XLEN-1:0]  s2_hh;
  logic             s2_neg;
  logic [1:0]       s2_op;
  logic [TAG_W-1:0] s2_tag;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_cross <= '0;
      s2_ll_lo <= '0;
      s2_ll_hi <= '0;
      s2_hh    <= '0;
      s2_neg   <= 1'b0;
      s2_op    <= '0;
      s2_tag   <= '0;
    end else if (!stall && s1_valid) begin
      s2_cross <= {1'b0, s1_lh} + {1'b0, s1_hl};
      s2_ll_lo <= s1_ll[H-1:0];
      s2_ll_hi <= s1_ll[XLEN-1:H];
      s2_hh    <= s1_hh;
      s2_neg   <= s1_neg;
      s2_op    <= s1_op;
      s2_tag   <= s1_tag;
    end
  end

  // ---------------- S3: final sum, sign fix-up, half select ----------------
  // The low H bits of the product are ll[H-1:0] untouched; only the upper
  // PW-H bits need the three-way add.
  logic [PW-H-1:0] p_upper;
  logic [PW-1:0]   p_mag;
  logic [PW-1:0]   p_fin;
  logic [XLEN-1:0] result_c;

  always_comb begin
    p_upper  = (PW-H)'(s2_ll_hi) + (PW-H)'(s2_cross) + {s2_hh, {H{1'b0}}};
    p_mag    = {p_upper, s2_ll_lo};
    p_fin    = s2_neg ? (~p_mag + PW'(1)) : p_mag;
    result_c = (s2_op == OP_MUL) ? p_fin[XLEN-1:0] : p_fin[PW-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_result <= '0;
      out_tag    <= '0;
    end else if (!stall && s2_valid) begin
      out_result <= result_c;
      out_tag    <= s2_tag;
    end
  end

  // ---------------- stage valids ----------------
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid  <= accept;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
    end
  end

`ifdef VEDIC_MUL_STATS_EN
  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_ops   <= '0;
      stat_stall <= '0;
    end else begin
      if (out_valid && out_ready) stat_ops <= stat_ops + 32'd1;
      if (stall) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule
